// File: rtl/cargador_pkg.sv
// ============================================================================
// cargador_pkg
// Shared types and constants for the program loader and its instruction RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cargador_pkg;

    localparam int P_ANCHO_DIR  = 8;
    localparam int P_ANCHO_INST = 9;

    localparam logic [7:0]              C_CABECERA = 8'hA5;
    localparam logic [P_ANCHO_INST-1:0] C_INST_NOP = 9'h000;

    typedef enum logic [2:0] {
        S_ESPERA_CAB = 3'd0,
        S_LONGITUD   = 3'd1,
        S_ALTO       = 3'd2,
        S_BAJO       = 3'd3,
        S_CHECKSUM   = 3'd4,
        S_EJECUTA    = 3'd5,
        S_ERROR      = 3'd6
    } estado_t;

endpackage

`default_nettype wire

// File: rtl/memoria_de_instrucciones.sv
// ============================================================================
// memoria_de_instrucciones
// Single-write-port instruction RAM with one registered read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memoria_de_instrucciones #(
    parameter int P_PROF       = 256,
    parameter int P_ANCHO_DIR  = 8,
    parameter int P_ANCHO_INST = 9
) (
    input  logic                    i_Clk,
    input  logic                    i_We,
    input  logic [P_ANCHO_DIR-1:0]  i_Dir_esc,
    input  logic [P_ANCHO_INST-1:0] i_Dato_esc,
    input  logic [P_ANCHO_DIR-1:0]  i_Dir_lec,
    output logic [P_ANCHO_INST-1:0] o_Dato_lec
);

    logic [P_ANCHO_INST-1:0] r_mem [P_PROF];
    logic [P_ANCHO_INST-1:0] r_dato_lec;

    // Contents are deliberately not reset; the loader's length gate hides them.
    always_ff @(posedge i_Clk) begin
        if (i_We) begin
            r_mem[i_Dir_esc] <= i_Dato_esc;
        end
        r_dato_lec <= r_mem[i_Dir_lec];
    end

    assign o_Dato_lec = r_dato_lec;

endmodule

`default_nettype wire

// File: rtl/cargador_de_programa.sv
// ============================================================================
// cargador_de_programa
// Framed byte-stream program loader feeding a 256x9 instruction RAM; holds
// the processor in reset until a frame with a valid checksum is loaded.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cargador_de_programa #(
    parameter int P_PROF       = 256,
    parameter int P_ANCHO_DIR  = 8,
    parameter int P_ANCHO_INST = 9
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic [7:0]              i_Byte,
    input  logic                    i_Byte_valido,
    output logic                    o_Byte_listo,
    input  logic [P_ANCHO_DIR-1:0]  i_Direccion_fetch,
    output logic [P_ANCHO_INST-1:0] o_Instruccion,
    output logic                    o_Rst_procesador,
    output logic                    o_Carga_completa,
    output logic                    o_Error
);

    import cargador_pkg::*;

    localparam int                  C_ANCHO_LONG = P_ANCHO_DIR + 1;
    localparam logic [C_ANCHO_LONG-1:0] C_LONG_MAX = C_ANCHO_LONG'(P_PROF);

    estado_t                 r_estado, w_estado_sig;
    logic [C_ANCHO_LONG-1:0] r_cuenta, w_cuenta_sig;
    logic [C_ANCHO_LONG-1:0] r_dir, w_dir_sig;
    logic [C_ANCHO_LONG-1:0] r_long, w_long_sig;
    logic [7:0]              r_xor, w_xor_sig;
    logic                    r_bit8, w_bit8_sig;
    logic                    r_byte_listo;
    logic                    r_dentro;
    logic                    w_acepta;
    logic                    w_we;
    logic [C_ANCHO_LONG-1:0] w_dir_inc;
    logic [C_ANCHO_LONG-1:0] w_long_efectiva;
    logic [P_ANCHO_INST-1:0] w_dato_ram;

    assign w_acepta  = i_Byte_valido & r_byte_listo;
    assign w_dir_inc = r_dir + 1'b1;

    always_comb begin
        w_estado_sig = r_estado;
        w_cuenta_sig = r_cuenta;
        w_dir_sig    = r_dir;
        w_long_sig   = r_long;
        w_xor_sig    = r_xor;
        w_bit8_sig   = r_bit8;
        w_we         = 1'b0;
        if (w_acepta) begin
            case (r_estado)
                S_ESPERA_CAB: begin
                    if (i_Byte == C_CABECERA) w_estado_sig = S_LONGITUD;
                end
                S_LONGITUD: begin
                    w_cuenta_sig = (i_Byte == 8'h00) ? C_LONG_MAX : C_ANCHO_LONG'(i_Byte);
                    w_dir_sig    = '0;
                    w_xor_sig    = 8'h00;
                    w_estado_sig = S_ALTO;
                end
                S_ALTO: begin
                    if (i_Byte[7:1] != 7'd0) begin
                        w_estado_sig = S_ERROR;
                    end else begin
                        w_bit8_sig   = i_Byte[0];
                        w_xor_sig    = r_xor ^ i_Byte;
                        w_estado_sig = S_BAJO;
                    end
                end
                S_BAJO: begin
                    w_we         = 1'b1;
                    w_xor_sig    = r_xor ^ i_Byte;
                    w_dir_sig    = w_dir_inc;
                    w_estado_sig = (w_dir_inc == r_cuenta) ? S_CHECKSUM : S_ALTO;
                end
                S_CHECKSUM: begin
                    if (i_Byte == r_xor) begin
                        w_long_sig   = r_cuenta;
                        w_estado_sig = S_EJECUTA;
                    end else begin
                        w_estado_sig = S_ERROR;
                    end
                end
                S_EJECUTA: begin
                    if (i_Byte == C_CABECERA) begin
                        w_long_sig   = '0;
                        w_estado_sig = S_LONGITUD;
                    end
                end
                S_ERROR: begin
                    if (i_Byte == C_CABECERA) w_estado_sig = S_LONGITUD;
                end
                default: w_estado_sig = S_ESPERA_CAB;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_estado     <= S_ESPERA_CAB;
            r_cuenta     <= '0;
            r_dir        <= '0;
            r_long       <= '0;
            r_xor        <= 8'h00;
            r_bit8       <= 1'b0;
            r_byte_listo <= 1'b0;
        end else begin
            r_estado     <= w_estado_sig;
            r_cuenta     <= w_cuenta_sig;
            r_dir        <= w_dir_sig;
            r_long       <= w_long_sig;
            r_xor        <= w_xor_sig;
            r_bit8       <= w_bit8_sig;
            r_byte_listo <= 1'b1;
        end
    end

    // Gate compares against the length that takes effect at this same edge,
    // so a reload blanks the fetch path and a fresh load exposes it at once.
    assign w_long_efectiva = i_Rst ? '0 : w_long_sig;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_dentro <= 1'b0;
        end else begin
            r_dentro <= (C_ANCHO_LONG'(i_Direccion_fetch) < w_long_efectiva);
        end
    end

    memoria_de_instrucciones #(
        .P_PROF       (P_PROF),
        .P_ANCHO_DIR  (P_ANCHO_DIR),
        .P_ANCHO_INST (P_ANCHO_INST)
    ) u_memoria (
        .i_Clk      (i_Clk),
        .i_We       (w_we),
        .i_Dir_esc  (r_dir[P_ANCHO_DIR-1:0]),
        .i_Dato_esc ({r_bit8, i_Byte}),
        .i_Dir_lec  (i_Direccion_fetch),
        .o_Dato_lec (w_dato_ram)
    );

    assign o_Instruccion    = r_dentro ? w_dato_ram : C_INST_NOP;
    assign o_Byte_listo     = r_byte_listo;
    assign o_Rst_procesador = (r_estado != S_EJECUTA);
    assign o_Carga_completa = (r_estado == S_EJECUTA);
    assign o_Error          = (r_estado == S_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_cargador_de_programa.sv
// ============================================================================
// tb_cargador_de_programa
// Directed, table-driven checks of framing, checksum, reload and fetch gating.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cargador_de_programa;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_in;
    logic       byte_valido;
    logic       byte_listo;
    logic [7:0] dir_fetch;
    logic [8:0] instruccion;
    logic       rst_proc;
    logic       carga;
    logic       error;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [7:0] dir;
        logic [8:0] inst;
    } fetch_vec_t;

    fetch_vec_t tabla_fetch [6];

    always #5 clk = ~clk;

    cargador_de_programa dut (
        .i_Clk             (clk),
        .i_Rst             (rst),
        .i_Byte            (byte_in),
        .i_Byte_valido     (byte_valido),
        .o_Byte_listo      (byte_listo),
        .i_Direccion_fetch (dir_fetch),
        .o_Instruccion     (instruccion),
        .o_Rst_procesador  (rst_proc),
        .o_Carga_completa  (carga),
        .o_Error           (error)
    );

    task automatic comprobar(input string nombre, input logic [15:0] real_v,
                             input logic [15:0] esperado);
        tests_run++;
        if (real_v !== esperado) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", nombre, real_v, esperado);
        end
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    task automatic enviar(input logic [7:0] b, input int hueco);
        for (int i = 0; i < hueco; i++) ciclo();
        byte_in     = b;
        byte_valido = 1'b1;
        ciclo();
        byte_valido = 1'b0;
        byte_in     = 8'h00;
    endtask

    task automatic estado(input string nombre, input logic e_rst, input logic e_carga,
                          input logic e_err);
        comprobar({nombre, "_rstproc"}, 16'(rst_proc), 16'(e_rst));
        comprobar({nombre, "_carga"},   16'(carga),    16'(e_carga));
        comprobar({nombre, "_error"},   16'(error),    16'(e_err));
    endtask

    task automatic fetch(input string nombre, input logic [7:0] a, input logic [8:0] esp);
        dir_fetch = a;
        ciclo();
        comprobar(nombre, 16'(instruccion), 16'(esp));
    endtask

    task automatic trama_normal(input int hueco);
        enviar(8'hA5, hueco);
        enviar(8'h02, hueco);
        enviar(8'h01, hueco);
        enviar(8'h23, hueco);
        enviar(8'h00, hueco);
        enviar(8'h45, hueco);
        enviar(8'h67, hueco);
    endtask

    logic [7:0] hi, lo, chk;
    logic [8:0] modelo [256];

    initial begin
        tabla_fetch[0] = '{8'h00, 9'h123};
        tabla_fetch[1] = '{8'h01, 9'h045};
        tabla_fetch[2] = '{8'h02, 9'h000};
        tabla_fetch[3] = '{8'h01, 9'h045};
        tabla_fetch[4] = '{8'hFF, 9'h000};
        tabla_fetch[5] = '{8'h00, 9'h123};

        rst = 1'b1; byte_in = 8'h00; byte_valido = 1'b0; dir_fetch = 8'h00;
        ciclo();
        comprobar("reset_listo", 16'(byte_listo), 16'd0);
        comprobar("reset_inst", 16'(instruccion), 16'h000);
        estado("reset", 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        ciclo();
        comprobar("listo_tras_reset", 16'(byte_listo), 16'd1);

        // Leading garbage, then a normal frame with gaps between bytes
        enviar(8'h00, 1);
        enviar(8'hFF, 2);
        enviar(8'hA5, 1);
        enviar(8'h02, 2);
        enviar(8'h01, 1);
        enviar(8'h23, 3);
        enviar(8'h00, 1);
        enviar(8'h45, 2);
        estado("antes_chk", 1'b1, 1'b0, 1'b0);
        fetch("fetch_durante_carga", 8'h00, 9'h000);
        enviar(8'h67, 1);
        estado("carga_ok", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            fetch($sformatf("fetch_tabla%0d", i), tabla_fetch[i].dir, tabla_fetch[i].inst);
        end

        // Reload while executing: NOP immediately after the A5 edge
        dir_fetch = 8'h00;
        enviar(8'hA5, 0);
        estado("recarga", 1'b1, 1'b0, 1'b0);
        comprobar("recarga_nop", 16'(instruccion), 16'h000);

        // Bad checksum on the reloaded frame
        enviar(8'h02, 0); enviar(8'h01, 0); enviar(8'h23, 0);
        enviar(8'h00, 0); enviar(8'h45, 0); enviar(8'h66, 0);
        estado("chk_malo", 1'b1, 1'b0, 1'b1);
        fetch("chk_malo_fetch", 8'h00, 9'h000);
        enviar(8'h67, 0);
        comprobar("error_descarta", 16'(error), 16'd1);
        enviar(8'hA5, 0);
        comprobar("a5_limpia_error", 16'(error), 16'd0);

        // Illegal high byte
        enviar(8'h01, 0);
        enviar(8'h03, 0);
        estado("alto_ilegal", 1'b1, 1'b0, 1'b1);
        enviar(8'h45, 0);
        enviar(8'h44, 0);
        comprobar("alto_ilegal_descarta", 16'(error), 16'd1);

        // Reset mid-load
        enviar(8'hA5, 0);
        enviar(8'h02, 0);
        enviar(8'h01, 0);
        rst = 1'b1;
        ciclo();
        rst = 1'b0;
        comprobar("rst_medio_listo", 16'(byte_listo), 16'd0);
        comprobar("rst_medio_inst", 16'(instruccion), 16'h000);
        estado("rst_medio", 1'b1, 1'b0, 1'b0);
        fetch("rst_medio_fetch", 8'h00, 9'h000);
        trama_normal(0);
        estado("tras_rst_carga", 1'b0, 1'b1, 1'b0);
        fetch("tras_rst_fetch1", 8'h01, 9'h045);
        fetch("tras_rst_fetch0", 8'h00, 9'h123);

        // Length 0 means 256 words
        enviar(8'hA5, 0);
        enviar(8'h00, 0);
        chk = 8'h00;
        for (int i = 0; i < 256; i++) begin
            hi = {7'd0, i[0]};
            lo = i[7:0] ^ 8'h5A;
            modelo[i] = {i[0], lo};
            chk = chk ^ hi ^ lo;
            enviar(hi, 0);
            enviar(lo, 0);
        end
        estado("n256_antes_chk", 1'b1, 1'b0, 1'b0);
        enviar(chk, 0);
        estado("n256_carga", 1'b0, 1'b1, 1'b0);
        fetch("n256_fetch_ff", 8'hFF, 9'h1A5);
        fetch("n256_fetch_00", 8'h00, modelo[0]);
        fetch("n256_fetch_80", 8'h80, modelo[128]);
        fetch("n256_fetch_37", 8'h37, modelo[55]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cargador_de_programa.md
# cargador_de_programa

Program loader and instruction memory that sits directly upstream of the processor's instruction input. It receives a framed byte stream and assembles 9-bit instructions into a 256-word instruction RAM. It serves the processor's fetch address with the stored instruction and holds the processor in reset until a load completes with a valid checksum.

## Interface
- P_PROF, 256: instruction RAM depth in words.
- P_ANCHO_DIR, 8: fetch address width.
- P_ANCHO_INST, 9: instruction width.

- i_Clk  in  1  single clock; all logic on rising edge.
- i_Rst  in  1  reset, synchronous and active-high.
- i_Byte  in  8  loader byte.
- i_Byte_valido  in  1  i_Byte is valid this cycle.
- o_Byte_listo  out  1  block can accept a byte.
- i_Direccion_fetch  in  8  fetch address, driven by the processor's instruction-address output.
- o_Instruccion  out  9  fetched instruction, driving the processor's instruction input.
- o_Rst_procesador  out  1  processor reset request; high while no valid program is loaded.
- o_Carga_completa  out  1  a valid program is loaded and executing.
- o_Error  out  1  the last frame was rejected.

## Operation
- A byte is accepted on a rising edge where i_Byte_valido and o_Byte_listo are both 1. Gaps in i_Byte_valido are legal in every state.
- Frame format:
  - header 8'hA5;
  - length N (1..255; 0 means 256);
  - N pairs of {high byte: bit0 = inst[8], bits 7:1 must be 0; low byte: inst[7:0]};
  - checksum byte = XOR of all 2N pair bytes.
- FSM states: S_ESPERA_CAB, S_LONGITUD, S_ALTO, S_BAJO, S_CHECKSUM, S_EJECUTA, S_ERROR.
- S_ESPERA_CAB: a non-A5 byte is discarded; A5 goes to S_LONGITUD.
- S_LONGITUD: latch N into a 9-bit count, clear the write address and running XOR, then go to S_ALTO.
- S_ALTO: if bits 7:1 ≠ 0, go to S_ERROR. Otherwise latch bit0, update the XOR, and go to S_BAJO.
- S_BAJO: write {bit0, byte} to RAM[address], update the XOR, and increment the address.
  - If the address reaches N, go to S_CHECKSUM; otherwise go to S_ALTO.
- S_CHECKSUM: on a match, go to S_EJECUTA and set the loaded-length register to N. On a mismatch, go to S_ERROR.
- S_EJECUTA: an A5 byte starts a reload. The block goes to S_LONGITUD, clears the loaded length, and reasserts the processor reset. Other bytes are discarded.
- S_ERROR: A5 goes to S_LONGITUD and clears o_Error. Other bytes are discarded.
- Fetch behaviour:
  - If i_Direccion_fetch < loaded length, o_Instruccion = RAM[addr].
  - Otherwise o_Instruccion = 9'h000 (NOP).
  - Loaded length is 0 during any load, error, or reset, so the output is NOP in those conditions.
- o_Rst_procesador = 1 in every state except S_EJECUTA.
- o_Carga_completa = 1 only in S_EJECUTA.
- o_Error = 1 only in S_ERROR.

## Timing
- Reset values:
  - state S_ESPERA_CAB;
  - o_Byte_listo 0;
  - o_Instruccion 9'h000;
  - o_Rst_procesador 1;
  - o_Carga_completa 0;
  - o_Error 0;
  - loaded length, address, and XOR all 0.
- RAM contents are not reset. The loaded-length gate makes any stale contents unobservable.
- o_Byte_listo is registered. It is 0 during the reset cycle and 1 from the first cycle after reset onward, in all states.
- Fetch has 1-cycle latency: an address presented at edge k appears on o_Instruccion after edge k+1.
- A RAM write made at edge k is readable by a fetch presented at edge k+1.
- State outputs are registered. The accepting edge of the checksum byte moves the FSM to S_EJECUTA, so o_Carga_completa rises and o_Rst_procesador falls right after that edge.
- Reset mid-load aborts the frame. All outputs take their reset values after the reset edge.
- Reset has priority over a simultaneous byte acceptance.

## Structure
- Package cargador_pkg contains:
  - the state enum;
  - C_CABECERA = 8'hA5;
  - C_INST_NOP = 9'h000;
  - widths P_ANCHO_DIR and P_ANCHO_INST.
- Sub-module memoria_de_instrucciones: P_PROF × P_ANCHO_INST synchronous RAM with one write port and one registered read port.
- The NOP gate on the fetch path must see the same read address as the RAM, so the comparison with the loaded length is registered alongside it.

## Test plan
- Normal load: A5,02,01,23,00,45,67.
  - o_Carga_completa goes to 1 and o_Rst_procesador to 0 after the checksum edge.
  - Fetch 0 → 9'h123, fetch 1 → 9'h045, fetch 2 → 9'h000, each one cycle later.
- Bad checksum: the same frame with 66 as the checksum byte.
  - o_Error = 1, o_Rst_procesador stays 1, fetch 0 → 9'h000.
  - Then A5 clears o_Error.
- Illegal high byte: A5,01,03.
  - o_Error = 1 right after the 03 edge; the remaining bytes are discarded.
- Leading garbage: 00,FF, then the normal load frame (first scenario).
  - Loads correctly, with gaps in i_Byte_valido between bytes.
- Reset mid-load: A5,02,01, then i_Rst for 1 cycle.
  - All outputs take reset values and fetch 0 → 9'h000.
  - A following full frame loads correctly.
- Reload while executing: A5 in S_EJECUTA.
  - o_Rst_procesador = 1 and o_Carga_completa = 0 after that edge, and fetch returns NOP.
- Length 0 (= 256): a frame of 256 pairs loads all addresses.
  - Fetch FF returns the last word.
